// File: rtl/piso_shift_engine.sv
// Parallel-in/serial-out shift engine: loads a word, then rotates or shifts it out
// one position per prescaler tick, with a serial output, a busy flag and a done pulse.
module piso_shift_engine #(
   parameter int WIDTH    = 16,
   parameter int IN_WIDTH = 8,
   parameter int DIV      = 50000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IN_WIDTH-1:0] sw,
   input  logic                load,
   input  logic                start,
   input  logic                stop,
   input  logic [1:0]          mode,
   input  logic                ser_in,
   output logic [WIDTH-1:0]    y,
   output logic                ser_out,
   output logic                busy,
   output logic                tick,
   output logic                done
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [PW-1:0] PS_LAST  = PW'(DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

   typedef enum logic [1:0] {
      MODE_ROL   = 2'b00,
      MODE_ROR   = 2'b01,
      MODE_SHOUT = 2'b10,
      MODE_HOLD  = 2'b11
   } mode_e;

   logic [PW-1:0] ps_cnt;
   logic [CW-1:0] step_cnt;
   mode_e         step_mode;
   logic          do_start;
   logic          do_step;

   assign step_mode = mode_e'(mode);
   assign do_start  = start && !load && !stop;
   assign do_step   = busy && tick && !load && !stop && !start;
   assign ser_out   = y[WIDTH-1];

   // Clock-enable prescaler; start re-phases it so the first step lands DIV cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_cnt <= '0;
         tick   <= 1'b0;
      end else if (do_start) begin
         ps_cnt <= '0;
         tick   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let tick and ps_cnt both see the old ps_cnt.
         tick   <= (ps_cnt == PS_LAST);
         ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         step_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (load) begin
            y        <= WIDTH'(sw);
            busy     <= 1'b0;
            step_cnt <= '0;
         end else if (stop) begin
            busy <= 1'b0;
         end else if (start) begin
            busy     <= 1'b1;
            step_cnt <= '0;
         end else if (do_step) begin
            unique case (step_mode)
               MODE_ROL:   y <= {y[WIDTH-2:0], y[WIDTH-1]};
               MODE_ROR:   y <= {y[0], y[WIDTH-1:1]};
               MODE_SHOUT: begin
                  y <= {y[WIDTH-2:0], ser_in};
                  // Saturating compare keeps the count bounded even if entered at WIDTH.
                  if (step_cnt >= CNT_LAST) begin
                     step_cnt <= CNT_FULL;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     step_cnt <= step_cnt + 1'b1;
                  end
               end
               MODE_HOLD:  y <= y;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_piso_shift_engine.sv
// Bench for piso_shift_engine: directed scenarios plus random control traffic,
// checked every cycle against a behavioural model for a DIV=4 and a DIV=1 instance.
module tb_piso_shift_engine;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] sw = '0;
   logic load = 1'b0, start = 1'b0, stop = 1'b0, ser_in = 1'b0;
   logic [1:0] mode = 2'b00;

   logic [7:0] y_o    [2];
   logic       ser_o  [2];
   logic       busy_o [2];
   logic       tick_o [2];
   logic       done_o [2];

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;
   int done_seen = 0;

   always #5 clk = ~clk;

   piso_shift_engine #(.WIDTH(W), .IN_WIDTH(8), .DIV(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .sw(sw), .load(load), .start(start), .stop(stop),
      .mode(mode), .ser_in(ser_in), .y(y_o[0]), .ser_out(ser_o[0]),
      .busy(busy_o[0]), .tick(tick_o[0]), .done(done_o[0]));

   piso_shift_engine #(.WIDTH(W), .IN_WIDTH(8), .DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .sw(sw), .load(load), .start(start), .stop(stop),
      .mode(mode), .ser_in(ser_in), .y(y_o[1]), .ser_out(ser_o[1]),
      .busy(busy_o[1]), .tick(tick_o[1]), .done(done_o[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state: edges_since_clear counts clock edges since the prescaler was last zeroed.
   typedef struct {
      logic [7:0] y;
      bit         busy;
      bit         done;
      bit         tick;
      int         edges_since_clear;
      int         shifted;
   } model_t;

   model_t m [2];
   int     div_of [2] = '{4, 1};

   function automatic model_t model_next(model_t s, int div);
      model_t n = s;
      n.done = 1'b0;
      n.edges_since_clear = s.edges_since_clear + 1;
      n.tick = (n.edges_since_clear % div) == 0;
      if (load) begin
         n.y = sw;
         n.busy = 1'b0;
         n.shifted = 0;
      end else if (stop) begin
         n.busy = 1'b0;
      end else if (start) begin
         n.busy = 1'b1;
         n.edges_since_clear = 0;
         n.tick = 1'b0;
         n.shifted = 0;
      end else if (s.busy && s.tick) begin
         case (mode)
            2'b00: n.y = 8'((int'(s.y) * 2) % 256 + int'(s.y) / 128);
            2'b01: n.y = 8'(int'(s.y) / 2 + (int'(s.y) % 2) * 128);
            2'b10: begin
               n.y = 8'((int'(s.y) * 2) % 256 + int'(ser_in));
               n.shifted = s.shifted + 1;
               if (n.shifted >= W) begin
                  n.shifted = W;
                  n.busy = 1'b0;
                  n.done = 1'b1;
               end
            end
            default: n.y = s.y;
         endcase
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) m[i] <= '{default: 0};
      end else begin
         for (int i = 0; i < 2; i++) m[i] <= model_next(m[i], div_of[i]);
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("y[%0d]", i),    y_o[i],    m[i].y);
            check($sformatf("busy[%0d]", i), busy_o[i], m[i].busy);
            check($sformatf("tick[%0d]", i), tick_o[i], m[i].tick);
            check($sformatf("done[%0d]", i), done_o[i], m[i].done);
            check($sformatf("ser[%0d]", i),  ser_o[i],  m[i].y[7]);
         end
         if (done_o[0]) done_seen++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_word(input logic [7:0] v);
      sw = v; load = 1'b1; cyc(1); load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cyc(1); stop = 1'b0;
   endtask

   initial begin
      logic [7:0] v;
      cyc(2);
      rst_n = 1'b1;
      checking = 1'b1;
      cyc(1);
      check("reset_y", y_o[0], 8'h00);
      check("reset_busy", busy_o[0], 1'b0);

      // Rotate left from A5
      mode = 2'b00;
      load_word(8'hA5);
      pulse_start();
      cyc(5); check("rol_1", y_o[0], 8'h4B);
      cyc(4); check("rol_2", y_o[0], 8'h96);
      cyc(4); check("rol_3", y_o[0], 8'h2D);
      check("rol_busy", busy_o[0], 1'b1);
      pulse_stop();

      // Rotate right from 01, full revolution
      mode = 2'b01;
      load_word(8'h01);
      pulse_start();
      cyc(5); check("ror_1", y_o[0], 8'h80);
      cyc(4); check("ror_2", y_o[0], 8'h40);
      cyc(4); check("ror_3", y_o[0], 8'h20);
      cyc(20); check("ror_8", y_o[0], 8'h01);
      pulse_stop();

      // Shift-out C3 with zero fill
      mode = 2'b10; ser_in = 1'b0;
      load_word(8'hC3);
      done_seen = 0;
      v = 8'hC3;
      check("shout_ser0", ser_o[0], v[7]);
      pulse_start();
      for (int k = 1; k <= 8; k++) begin
         cyc(k == 1 ? 5 : 4);
         v = {v[6:0], 1'b0};
         check($sformatf("shout_ser%0d", k), ser_o[0], v[7]);
      end
      check("shout_y", y_o[0], 8'h00);
      check("shout_busy", busy_o[0], 1'b0);
      check("shout_done", done_o[0], 1'b1);
      cyc(1); check("shout_done_low", done_o[0], 1'b0);
      cyc(8); check("shout_done_once", done_seen, 1);

      // Priority: load beats stop and start
      sw = 8'h3C; load = 1'b1; start = 1'b1; stop = 1'b1;
      cyc(1);
      load = 1'b0; start = 1'b0; stop = 1'b0;
      check("prio_y", y_o[0], 8'h3C);
      check("prio_busy", busy_o[0], 1'b0);
      pulse_start();
      cyc(1);
      pulse_stop();
      cyc(10);
      check("stop_y", y_o[0], 8'h3C);
      check("stop_busy", busy_o[0], 1'b0);

      // Asynchronous reset mid shift-out
      load_word(8'hAA);
      pulse_start();
      cyc(13);
      #2 rst_n = 1'b0;
      #1;
      check("async_y", y_o[0], 8'h00);
      check("async_busy", busy_o[0], 1'b0);
      check("async_tick", tick_o[0], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("post_rst_tick_lo%0d", k), tick_o[0], 1'b0);
         cyc(1);
      end
      check("post_rst_tick_hi", tick_o[0], 1'b1);
      pulse_stop();

      // DIV=1: hold then rotate
      mode = 2'b11;
      load_word(8'h81);
      pulse_start();
      cyc(3);
      check("div1_hold", y_o[1], 8'h81);
      check("div1_busy", busy_o[1], 1'b1);
      mode = 2'b00;
      cyc(1);
      check("div1_rol", y_o[1], 8'h03);
      check("div1_tick", tick_o[1], 1'b1);
      cyc(1);
      check("div1_rol2", y_o[1], 8'h06);
      pulse_stop();

      // Random control traffic
      for (int c = 0; c < 3000; c++) begin
         load   = ($urandom_range(0, 24) == 0);
         stop   = ($urandom_range(0, 29) == 0);
         start  = ($urandom_range(0, 14) == 0);
         ser_in = 1'($urandom_range(0, 1));
         sw     = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         cyc(1);
      end
      load = 1'b0; stop = 1'b0; start = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
